// File: rtl/s2p_rx.sv
// s2p_rx: serial-to-parallel receiver.
// Takes an LSB-first serial stream framed by valid_i and assembles WIDTH-bit
// words. Finished words go into a 2-entry output FIFO that is drained with a
// valid/ready handshake. Also reports aborted frames and words dropped on a
// full buffer.
//
// state | meaning
// IDLE  | no frame in progress; a valid_i=1 here samples bit 0
// SHIFT | frame in progress; bits 1..WIDTH-1 are still to come
module s2p_rx #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] parallel_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             frame_err_o,
  output logic             overflow_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_ferr;
  logic             w_start;
  logic             w_shift;
  logic             w_push;
  logic             w_abort;
  logic             w_last;
  logic [WIDTH-1:0] w_word;

  logic [WIDTH-1:0] r_mem [2];
  logic             r_rd;
  logic             r_wr;
  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_last;
  logic             r_ovf;
  logic             w_pop;
  logic             w_full;
  logic             w_wr;

  assign w_last = (r_cnt == CW'(WIDTH - 1));
  // The last bit goes straight into the pushed word; it never lands in r_shift.
  assign w_word = {serial_i, r_shift[WIDTH-2:0]};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and the per-cycle frame events.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_push      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (valid_i) begin
          w_start     = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (valid_i) begin
          if (w_last) begin
            w_push      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_shift = 1'b1;
          end
        end else begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bit counter and shift register; a new frame clears the stale upper bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_start) begin
      r_cnt   <= CW'(1);
      r_shift <= {{(WIDTH-1){1'b0}}, serial_i};
    end else if (w_shift) begin
      r_shift[r_cnt] <= serial_i;
      r_cnt          <= r_cnt + 1'b1;
    end else if (w_push) begin
      r_cnt <= '0;
    end else if (w_abort) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end
  end

  // Aborted-frame pulse, one cycle after the abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ferr <= 1'b0;
    else        r_ferr <= w_abort;
  end

  assign w_pop  = out_valid_o & out_ready_i;
  assign w_full = (r_count == 2'(DEPTH));
  // A full buffer still takes the word if the head leaves on the same edge.
  assign w_wr   = w_push & (~w_full | w_pop);

  // Output FIFO: storage, pointers, occupancy, last-popped word, sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_count  <= 2'd0;
      r_last   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr] <= w_word;
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd   <= ~r_rd;
        r_last <= r_mem[r_rd];
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_push && !w_wr) r_ovf <= 1'b1;
    end
  end

  assign out_valid_o = (r_count != 2'd0);
  // While empty, show the word popped last rather than a stale slot.
  assign parallel_o  = out_valid_o ? r_mem[r_rd] : r_last;
  assign busy_o      = (r_state == SHIFT);
  assign frame_err_o = r_ferr;
  assign overflow_o  = r_ovf;

endmodule

// File: tb/tb_s2p_rx.sv
// Directed bench for s2p_rx (WIDTH=4). Inputs change and outputs are sampled
// 1ns after each rising edge.
module tb_s2p_rx;

  logic       clk;
  logic       reset;
  logic       serial_i;
  logic       valid_i;
  logic [3:0] parallel_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic       busy_o;
  logic       frame_err_o;
  logic       overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  s2p_rx #(.WIDTH(4), .DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .serial_i    (serial_i),
    .valid_i     (valid_i),
    .parallel_o  (parallel_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o),
    .overflow_o  (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    valid_i  = 1'b1;
    serial_i = b;
    tick();
  endtask

  // Sends one word LSB first and drops valid_i without spending a cycle,
  // so consecutive calls produce back-to-back frames.
  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) send_bit(w[i]);
    valid_i  = 1'b0;
    serial_i = 1'b0;
  endtask

  task automatic do_reset();
    valid_i  = 1'b0;
    serial_i = 1'b0;
    reset    = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] seq2;
    reset       = 1'b1;
    valid_i     = 1'b0;
    serial_i    = 1'b0;
    out_ready_i = 1'b0;
    #2;

    // Test 1: reset state, then a single word 1,0,1,1 -> 4'hD.
    reset = 1'b0;
    tick();
    tick();
    chk("rst_parallel",  32'(parallel_o),  32'h0);
    chk("rst_out_valid", 32'(out_valid_o), 32'h0);
    chk("rst_busy",      32'(busy_o),      32'h0);
    chk("rst_frame_err", 32'(frame_err_o), 32'h0);
    chk("rst_overflow",  32'(overflow_o),  32'h0);
    reset       = 1'b1;
    out_ready_i = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      valid_i  = 1'b1;
      serial_i = (i == 1) ? 1'b0 : 1'b1;
      chk("t1_busy", 32'(busy_o), (i == 0) ? 32'h0 : 32'h1);
      chk("t1_no_valid_early", 32'(out_valid_o), 32'h0);
      tick();
    end
    valid_i = 1'b0;
    chk("t1_out_valid", 32'(out_valid_o), 32'h1);
    chk("t1_word",      32'(parallel_o),  32'hD);
    chk("t1_busy_end",  32'(busy_o),      32'h0);
    tick();
    chk("t1_popped",    32'(out_valid_o), 32'h0);
    chk("t1_hold_last", 32'(parallel_o),  32'hD);

    // Test 2: back-to-back frames 1,0,1,1 | 0,0,1,0 -> 4'hD then 4'h4.
    seq2 = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      send_bit(seq2[i]);
      chk("t2_no_ferr", 32'(frame_err_o), 32'h0);
      if (i == 3) begin
        chk("t2_w0_valid", 32'(out_valid_o), 32'h1);
        chk("t2_w0",       32'(parallel_o),  32'hD);
      end
      if (i == 4) chk("t2_busy_b2b", 32'(busy_o), 32'h1);
    end
    valid_i = 1'b0;
    chk("t2_w1_valid", 32'(out_valid_o), 32'h1);
    chk("t2_w1",       32'(parallel_o),  32'h4);
    tick();
    chk("t2_no_ferr_end", 32'(frame_err_o), 32'h0);
    chk("t2_empty",       32'(out_valid_o), 32'h0);

    // Test 3: backpressure, third word overflows and is dropped.
    out_ready_i = 1'b0;
    send_word(4'hA);
    chk("t3_a_valid", 32'(out_valid_o), 32'h1);
    chk("t3_a_head",  32'(parallel_o),  32'hA);
    send_word(4'h5);
    chk("t3_head_held", 32'(parallel_o), 32'hA);
    chk("t3_no_ovf",    32'(overflow_o), 32'h0);
    send_word(4'hF);
    chk("t3_ovf",        32'(overflow_o), 32'h1);
    chk("t3_head_still", 32'(parallel_o), 32'hA);
    tick();
    out_ready_i = 1'b1;
    chk("t3_pop0_valid", 32'(out_valid_o), 32'h1);
    chk("t3_pop0",       32'(parallel_o),  32'hA);
    tick();
    chk("t3_pop1_valid", 32'(out_valid_o), 32'h1);
    chk("t3_pop1",       32'(parallel_o),  32'h5);
    tick();
    chk("t3_drained",    32'(out_valid_o), 32'h0);
    chk("t3_no_f",       32'(parallel_o),  32'h5);
    chk("t3_ovf_sticky", 32'(overflow_o),  32'h1);

    do_reset();
    chk("rst2_overflow", 32'(overflow_o), 32'h0);

    // Test 4: abort after two bits, then a clean 4'h3.
    out_ready_i = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    valid_i  = 1'b0;
    serial_i = 1'b1;
    chk("t4_busy_mid", 32'(busy_o), 32'h1);
    tick();
    chk("t4_ferr",    32'(frame_err_o), 32'h1);
    chk("t4_busy",    32'(busy_o),      32'h0);
    chk("t4_no_word", 32'(out_valid_o), 32'h0);
    tick();
    chk("t4_ferr_one_cycle", 32'(frame_err_o), 32'h0);
    chk("t4_no_word2",       32'(out_valid_o), 32'h0);
    send_word(4'h3);
    chk("t4_valid", 32'(out_valid_o), 32'h1);
    chk("t4_word",  32'(parallel_o),  32'h3);
    tick();

    // Test 5: full buffer, push of 4'h3 coincides with a pop.
    out_ready_i = 1'b0;
    send_word(4'h1);
    send_word(4'h2);
    chk("t5_head1", 32'(parallel_o), 32'h1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    out_ready_i = 1'b1;
    send_bit(1'b0);
    valid_i = 1'b0;
    chk("t5_no_ovf", 32'(overflow_o),  32'h0);
    chk("t5_valid2", 32'(out_valid_o), 32'h1);
    chk("t5_head2",  32'(parallel_o),  32'h2);
    tick();
    chk("t5_valid3", 32'(out_valid_o), 32'h1);
    chk("t5_head3",  32'(parallel_o),  32'h3);
    tick();
    chk("t5_empty",  32'(out_valid_o), 32'h0);
    chk("t5_no_ovf_end", 32'(overflow_o), 32'h0);

    // Test 6: asynchronous reset mid-frame, then 4'h9.
    send_bit(1'b1);
    send_bit(1'b0);
    #2;
    reset   = 1'b0;
    valid_i = 1'b0;
    #1;
    chk("t6_busy",      32'(busy_o),      32'h0);
    chk("t6_parallel",  32'(parallel_o),  32'h0);
    chk("t6_out_valid", 32'(out_valid_o), 32'h0);
    chk("t6_ferr",      32'(frame_err_o), 32'h0);
    tick();
    chk("t6_ferr_in_rst", 32'(frame_err_o), 32'h0);
    reset = 1'b1;
    tick();
    chk("t6_ferr_after", 32'(frame_err_o), 32'h0);
    for (int i = 0; i < 4; i++) begin
      send_bit((i == 0 || i == 3) ? 1'b1 : 1'b0);
      chk("t6_ferr_frame", 32'(frame_err_o), 32'h0);
    end
    valid_i = 1'b0;
    chk("t6_valid", 32'(out_valid_o), 32'h1);
    chk("t6_word",  32'(parallel_o),  32'h9);
    tick();
    chk("t6_empty", 32'(out_valid_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
